// File: rtl/cachebus_responder_pkg.sv
// Shared types and derived sizes for the cache line bus responder.
package cachebus_responder_pkg;

    localparam int DEF_PA_BITS  = 34;
    localparam int DEF_LINELEN  = 512;
    localparam int DEF_BEATLEN  = 64;
    localparam int OFFSETLEN    = $clog2(DEF_LINELEN / 8);
    localparam int BEATSPERLINE = DEF_LINELEN / DEF_BEATLEN;
    localparam int DEF_LOGBWPL  = $clog2(BEATSPERLINE);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RDREQ,
        RDWAIT,
        ACK
    } state_t;

    // Byte-offset width of a line, used to drop the in-line address bits.
    function automatic int offset_len(input int linelen);
        return $clog2(linelen / 8);
    endfunction

endpackage

// File: rtl/cachebus_responder_busbeatcounter.sv
// Beat index counter: counts accepted beats within a line, wraps naturally
// at the last beat because the beat count per line is a power of two.
module cachebus_responder_busbeatcounter
    import cachebus_responder_pkg::*;
#(
    parameter int WIDTH = DEF_LOGBWPL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so a combined clear/advance restarts at beat 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;
    assign o_last  = &r_count;

endmodule

// File: rtl/cachebus_responder.sv
// Memory-side responder for the cache line bus: splits line fetches and
// writebacks into beats on a request/valid memory port.
//
// state  | meaning
// IDLE   | waiting for a fetch and/or writeback request
// WRITE  | issuing writeback beats, cache indexed by BeatCount
// RDREQ  | issuing one read beat request
// RDWAIT | waiting for read data of the outstanding beat
// ACK    | one-cycle completion pulse to the cache
module cachebus_responder
    import cachebus_responder_pkg::*;
#(
    parameter int PA_BITS = DEF_PA_BITS,
    parameter int LINELEN = DEF_LINELEN,
    parameter int BEATLEN = DEF_BEATLEN,
    parameter int LOGBWPL = DEF_LOGBWPL
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATLEN-1:0] CacheWriteWord,
    output logic               CacheBusAck,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               MemReq,
    output logic               MemWrite,
    output logic [PA_BITS-1:0] MemAdr,
    output logic [BEATLEN-1:0] MemWData,
    input  logic               MemReady,
    input  logic               MemRValid,
    input  logic [BEATLEN-1:0] MemRData
);

    localparam int OFF_W  = offset_len(LINELEN);
    localparam int BEATS  = LINELEN / BEATLEN;
    localparam int BYTE_W = OFF_W - LOGBWPL;

    state_t                     r_state;
    state_t                     w_next;
    logic [PA_BITS-OFF_W-1:0]   r_line_adr;
    logic                       r_both;
    logic [LINELEN-1:0]         r_fetch_buf;
    logic                       w_cnt_en;
    logic                       w_cnt_clr;
    logic                       w_last;
    logic [LOGBWPL-1:0]         w_beat;
    logic                       w_ack;
    logic                       w_sel;
    logic                       w_req;
    logic                       w_wr;
    logic                       w_unused_adr_lo;

    // In-line offset bits of the request address carry no information.
    assign w_unused_adr_lo = ^CacheBusAdr[OFF_W-1:0];

    cachebus_responder_busbeatcounter #(.WIDTH(LOGBWPL)) u_beatcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_cnt_en),
        .i_clr   (w_cnt_clr),
        .o_count (w_beat),
        .o_last  (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Latch line address and request type when a transfer starts; later
    // changes on CacheBusRW/CacheBusAdr are ignored until the next IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_adr <= '0;
            r_both     <= 1'b0;
        end else if (r_state == IDLE && CacheBusRW != 2'b00) begin
            r_line_adr <= CacheBusAdr[PA_BITS-1:OFF_W];
            r_both     <= &CacheBusRW;
        end
    end

    // Next-state and Moore outputs; a combined request writes back first.
    always_comb begin
        w_next    = r_state;
        w_ack     = 1'b0;
        w_sel     = 1'b0;
        w_req     = 1'b0;
        w_wr      = 1'b0;
        w_cnt_en  = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (CacheBusRW[0])
                    w_next = WRITE;
                else if (CacheBusRW[1])
                    w_next = RDREQ;
            end
            WRITE: begin
                w_sel = 1'b1;
                w_req = 1'b1;
                w_wr  = 1'b1;
                if (MemReady) begin
                    w_cnt_en = 1'b1;
                    if (w_last) begin
                        if (r_both) begin
                            w_next    = RDREQ;
                            w_cnt_clr = 1'b1;
                        end else begin
                            w_next = ACK;
                        end
                    end
                end
            end
            RDREQ: begin
                w_req = 1'b1;
                if (MemReady)
                    w_next = RDWAIT;
            end
            RDWAIT: begin
                if (MemRValid) begin
                    w_cnt_en = 1'b1;
                    w_next   = w_last ? ACK : RDREQ;
                end
            end
            ACK: begin
                w_ack     = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Drop each returned read beat into its slot; other slots keep old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_buf <= '0;
        end else if (r_state == RDWAIT && MemRValid) begin
            for (int i = 0; i < BEATS; i++) begin
                if (w_beat == LOGBWPL'(i))
                    r_fetch_buf[i*BEATLEN +: BEATLEN] <= MemRData;
            end
        end
    end

    assign CacheBusAck = w_ack;
    assign SelBusBeat  = w_sel;
    assign BeatCount   = w_beat;
    assign FetchBuffer = r_fetch_buf;
    assign MemReq      = w_req;
    assign MemWrite    = w_wr;
    assign MemAdr      = {r_line_adr, w_beat, {BYTE_W{1'b0}}};
    assign MemWData    = CacheWriteWord;

endmodule

// File: tb/tb_cachebus_responder.sv
// Self-checking bench for cachebus_responder: directed and random line
// transfers against a memory/cache model kept in the bench.
module tb_cachebus_responder;
    import cachebus_responder_pkg::*;

    localparam int PA = 34;
    localparam int LL = 512;
    localparam int BL = 64;
    localparam int LW = 3;
    localparam int NB = BEATSPERLINE;
    localparam int W  = LL;

    typedef struct {
        logic [PA-1:0] adr;
        logic          wr;
        logic [BL-1:0] wd;
        logic          sel;
    } acc_t;

    logic          clk;
    logic          reset_n;
    logic [1:0]    CacheBusRW;
    logic [PA-1:0] CacheBusAdr;
    logic [BL-1:0] CacheWriteWord;
    logic          CacheBusAck;
    logic          SelBusBeat;
    logic [LW-1:0] BeatCount;
    logic [LL-1:0] FetchBuffer;
    logic          MemReq;
    logic          MemWrite;
    logic [PA-1:0] MemAdr;
    logic [BL-1:0] MemWData;
    logic          MemReady;
    logic          MemRValid;
    logic [BL-1:0] MemRData;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            rmode    = 0;
    bit            rrand    = 0;
    bit            spurious = 0;
    int            dmode    = 0;
    logic [31:0]   seed     = 32'h1234_5678;
    int            stall_left, n_stalls, sum_d, n_acks, rv_cnt, rv_d, last_lat;
    bit            rv_pend  = 0;
    logic [PA-1:0] rv_addr;
    acc_t          acc[$];
    logic [BL-1:0] line_w [NB];
    logic [LL-1:0] exp_fb;
    logic [LL-1:0] saved_fb;
    bit            seen;
    logic [PA-1:0] radr;

    cachebus_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .CacheBusRW     (CacheBusRW),
        .CacheBusAdr    (CacheBusAdr),
        .CacheWriteWord (CacheWriteWord),
        .CacheBusAck    (CacheBusAck),
        .SelBusBeat     (SelBusBeat),
        .BeatCount      (BeatCount),
        .FetchBuffer    (FetchBuffer),
        .MemReq         (MemReq),
        .MemWrite       (MemWrite),
        .MemAdr         (MemAdr),
        .MemWData       (MemWData),
        .MemReady       (MemReady),
        .MemRValid      (MemRValid),
        .MemRData       (MemRData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cache side: the word presented is the line word indexed by BeatCount.
    always_comb CacheWriteWord = line_w[BeatCount];

    // Memory contents as a pure function of the beat address.
    function automatic logic [BL-1:0] mem_data(input logic [PA-1:0] a, input int dm);
        if (dm == 0)
            return 64'(a[5:3]) * 64'h1111;
        else
            return {a[31:0] ^ seed, ~a[31:0] ^ (seed * 32'd3)};
    endfunction

    // Memory model: decides MemReady, returns read data after a delay,
    // and logs every accepted beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            rv_pend   = 1'b0;
            MemRValid = 1'b0;
            MemReady  = 1'b0;
        end else begin
            MemRValid = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    MemRValid = 1'b1;
                    MemRData  = mem_data(rv_addr, dmode);
                    rv_pend   = 1'b0;
                end else begin
                    rv_cnt = rv_cnt - 1;
                end
            end else if (spurious) begin
                MemRValid = 1'b1;
                MemRData  = {$urandom, $urandom};
            end
            if (rmode == 1)
                MemReady = ($urandom_range(0, 3) != 0);
            else if (rmode == 2 && MemReq && MemWrite && BeatCount == 3'd3 && stall_left > 0) begin
                MemReady   = 1'b0;
                stall_left = stall_left - 1;
            end else
                MemReady = 1'b1;
            if (MemReq && !MemReady) n_stalls = n_stalls + 1;
            if (MemReq && MemReady) begin
                acc.push_back('{adr: MemAdr, wr: MemWrite, wd: MemWData, sel: SelBusBeat});
                if (!MemWrite) begin
                    rv_d    = rrand ? int'($urandom_range(1, 3)) : 1;
                    sum_d   = sum_d + rv_d;
                    rv_cnt  = rv_d - 1;
                    rv_pend = 1'b1;
                    rv_addr = MemAdr;
                end
            end
            if (CacheBusAck) n_acks = n_acks + 1;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full line transfer; expectations come from the request type, the
    // memory model and the stall/delay counts the memory model chose.
    task automatic run_txn(input logic [1:0] rw, input logic [PA-1:0] adr,
                           input int rm, input bit rr, input int dm);
        logic [PA-1:0] base;
        int nw, nr, c0, lat;
        bit got;
        base = adr & ~PA'(LL / 8 - 1);
        nw = rw[0] ? NB : 0;
        nr = rw[1] ? NB : 0;
        rmode = rm; rrand = rr; dmode = dm;
        acc.delete();
        n_stalls = 0; sum_d = 0; n_acks = 0; stall_left = 4;
        CacheBusAdr = adr;
        CacheBusRW  = rw;
        c0  = cyc;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #2;
            if (CacheBusAck) begin
                got = 1'b1;
                lat = cyc - c0;
                CacheBusRW  = 2'b00;
                CacheBusAdr = {2'($urandom_range(0, 3)), $urandom};
            end
        end
        CacheBusRW = 2'b00;
        last_lat = lat;
        chk("ack_seen", W'(got), W'(1));
        @(posedge clk); #2;
        chk("ack_width", W'(CacheBusAck), W'(0));
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        chk("ack_count", W'(n_acks), W'(1));
        chk("latency", W'(lat), W'(nw + nr + n_stalls + sum_d + 1));
        if (nr > 0)
            for (int k = 0; k < NB; k++)
                exp_fb[k*BL +: BL] = mem_data(base + PA'(8 * k), dm);
        chk("fetch_buffer", FetchBuffer, exp_fb);
        chk("beat_idle", W'(BeatCount), W'(0));
        chk("accept_count", W'(acc.size()), W'(nw + nr));
        for (int i = 0; i < acc.size() && i < nw + nr; i++) begin
            if (i < nw) begin
                chk("wr_adr", W'(acc[i].adr), W'(base + PA'(8 * i)));
                chk("wr_flag", W'(acc[i].wr), W'(1));
                chk("wr_data", W'(acc[i].wd), W'(line_w[i]));
                chk("wr_sel", W'(acc[i].sel), W'(1));
            end else begin
                chk("rd_adr", W'(acc[i].adr), W'(base + PA'(8 * (i - nw))));
                chk("rd_flag", W'(acc[i].wr), W'(0));
                chk("rd_sel", W'(acc[i].sel), W'(0));
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        CacheBusRW  = 2'b00;
        CacheBusAdr = '0;
        MemReady    = 1'b0;
        MemRValid   = 1'b0;
        MemRData    = '0;
        exp_fb      = '0;
        for (int k = 0; k < NB; k++) line_w[k] = '0;

        #2;
        chk("rst_ack", W'(CacheBusAck), W'(0));
        chk("rst_sel", W'(SelBusBeat), W'(0));
        chk("rst_beat", W'(BeatCount), W'(0));
        chk("rst_fb", FetchBuffer, W'(0));
        chk("rst_req", W'(MemReq), W'(0));
        chk("rst_wr", W'(MemWrite), W'(0));
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Directed fetch: data 0x1111*beat, one-cycle read latency.
        run_txn(2'b10, 34'h0_8000_0040, 0, 0, 0);
        chk("fetch_lat17", W'(last_lat), W'(17));
        chk("fb_slice7", W'(FetchBuffer[511:448]), W'(64'h7777));
        chk("fb_slice1", W'(FetchBuffer[127:64]), W'(64'h1111));

        // Directed writeback: cache words 0xA0+beat.
        for (int k = 0; k < NB; k++) line_w[k] = 64'hA0 + 64'(k);
        run_txn(2'b01, 34'h0_8000_0000, 0, 0, 0);
        chk("wb_lat9", W'(last_lat), W'(9));

        // Writeback with MemReady low for 4 cycles on beat 3.
        for (int k = 0; k < NB; k++) line_w[k] = {$urandom, $urandom};
        run_txn(2'b01, 34'h1_2345_6780, 2, 0, 1);
        chk("stall_cycles", W'(n_stalls), W'(4));
        chk("stall_lat13", W'(last_lat), W'(13));

        // Combined writeback then fetch of the same line.
        seed = $urandom;
        for (int k = 0; k < NB; k++) line_w[k] = {$urandom, $urandom};
        run_txn(2'b11, 34'h0_8000_0000, 0, 0, 1);
        chk("both_lat25", W'(last_lat), W'(25));

        // Random requests, random stalls and read delays, unaligned addresses.
        for (int t = 0; t < 8; t++) begin
            seed = $urandom;
            for (int k = 0; k < NB; k++) line_w[k] = {$urandom, $urandom};
            radr = {2'($urandom_range(0, 3)), $urandom};
            run_txn(2'($urandom_range(1, 3)), radr, 1, 1, 1);
        end

        // Spurious read-valid while idle must not touch the buffer.
        saved_fb = FetchBuffer;
        spurious = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
        end
        spurious = 1'b0;
        chk("spur_idle_fb", FetchBuffer, exp_fb);
        chk("spur_idle_fb_saved", FetchBuffer, saved_fb);
        chk("spur_idle_beat", W'(BeatCount), W'(0));
        chk("spur_idle_ack", W'(n_acks), W'(1));
        @(posedge clk); #2;

        // Spurious read-valid throughout a writeback.
        spurious = 1'b1;
        for (int k = 0; k < NB; k++) line_w[k] = {$urandom, $urandom};
        run_txn(2'b01, 34'h2_0000_1fc0, 0, 0, 1);
        spurious = 1'b0;
        @(posedge clk); #2;

        // Reset during read beat 5, then a clean fetch.
        seed = $urandom;
        rmode = 0; rrand = 0; dmode = 1;
        acc.delete();
        n_acks = 0;
        CacheBusAdr = 34'h3_0000_0100;
        CacheBusRW  = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #2;
            if (MemReq && !MemWrite && BeatCount == 3'd5) seen = 1'b1;
        end
        chk("reach_beat5", W'(seen), W'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", W'(MemReq), W'(0));
        chk("mid_rst_wr", W'(MemWrite), W'(0));
        chk("mid_rst_beat", W'(BeatCount), W'(0));
        chk("mid_rst_fb", FetchBuffer, W'(0));
        chk("mid_rst_ack", W'(CacheBusAck), W'(0));
        chk("mid_rst_sel", W'(SelBusBeat), W'(0));
        CacheBusRW = 2'b00;
        exp_fb = '0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        chk("mid_rst_noack", W'(n_acks), W'(0));
        chk("mid_rst_idle", W'(MemReq), W'(0));
        seed = $urandom;
        run_txn(2'b10, 34'h3_0000_0100, 0, 0, 1);
        chk("post_rst_lat17", W'(last_lat), W'(17));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
